// File: rtl/alu_issue_if.sv
// ============================================================================
// Module      : alu_issue_if
// Description : Issue-stage bus: instruction in, ALU operands out, writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALU_Op;
    logic [4:0]  out_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data,
        input  in_ready, out_valid, A, B, ALU_Op, out_rd, illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_rd, wb_data,
        output in_ready, out_valid, A, B, ALU_Op, out_rd, illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue.sv
// ============================================================================
// Module      : alu_issue
// Description : RV32I OP/OP-IMM decode, register read, scoreboard and issue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue #(
    parameter bit WB_BYPASS = 1'b1
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    alu_issue_if.slave   bus
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_F7_ZERO    = 7'b0000000;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;

    logic [31:0] rf_q [32];
    logic [31:1] busy_q, busy_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  w_opcode, w_f7;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic        w_wb_hit;
    logic [31:0] w_rs1_val, w_rs2_val, w_b;
    logic [31:0] w_busy_eff;
    logic [3:0]  w_op;
    logic        w_legal, w_is_op, w_hazard, w_in_ready, w_fire;

    assign w_opcode = bus.in_instr[6:0];
    assign w_rd     = bus.in_instr[11:7];
    assign w_f3     = bus.in_instr[14:12];
    assign w_rs1    = bus.in_instr[19:15];
    assign w_rs2    = bus.in_instr[24:20];
    assign w_f7     = bus.in_instr[31:25];
    assign w_wb_hit = WB_BYPASS && bus.wb_valid && (bus.wb_rd != 5'd0);

    // Operand read with same-cycle writeback forwarding
    always_comb begin
        w_rs1_val = rf_q[w_rs1];
        w_rs2_val = rf_q[w_rs2];
        if (w_wb_hit && bus.wb_rd == w_rs1) w_rs1_val = bus.wb_data;
        if (w_wb_hit && bus.wb_rd == w_rs2) w_rs2_val = bus.wb_data;
        if (w_rs1 == 5'd0) w_rs1_val = 32'd0;
        if (w_rs2 == 5'd0) w_rs2_val = 32'd0;
    end

    always_comb begin
        w_busy_eff = 32'd0;
        for (int i = 1; i < 32; i++) begin
            w_busy_eff[i] = busy_q[i] && !(w_wb_hit && bus.wb_rd == 5'(i));
        end
    end

    always_comb begin
        w_legal = 1'b0;
        w_is_op = 1'b0;
        w_op    = {1'b0, w_f3};
        w_b     = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        case (w_opcode)
            c_OPC_OP: begin
                w_is_op = 1'b1;
                w_op    = {bus.in_instr[30], w_f3};
                w_b     = w_rs2_val;
                w_legal = (w_f7 == c_F7_ZERO) ||
                          (w_f7 == c_F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101));
            end
            c_OPC_OP_IMM: begin
                case (w_f3)
                    3'b001: begin
                        w_b     = {27'd0, w_rs2};
                        w_legal = (w_f7 == c_F7_ZERO);
                    end
                    3'b101: begin
                        w_b     = {27'd0, w_rs2};
                        w_op    = {bus.in_instr[30], w_f3};
                        w_legal = (w_f7 == c_F7_ZERO) || (w_f7 == c_F7_ALT);
                    end
                    default: w_legal = 1'b1;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal instructions bypass the hazard check so they never deadlock
    assign w_hazard   = w_busy_eff[w_rs1] | (w_is_op & w_busy_eff[w_rs2]) | w_busy_eff[w_rd];
    assign w_in_ready = rst_n && (!out_valid_q || bus.out_ready) && (!w_legal || !w_hazard);
    assign w_fire     = bus.in_valid && w_in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        rd_d        = rd_q;
        illegal_d   = w_fire && !w_legal;
        busy_d      = busy_q;
        if (bus.out_ready) out_valid_d = 1'b0;
        if (w_fire && w_legal) begin
            out_valid_d = 1'b1;
            a_d         = w_rs1_val;
            b_d         = w_b;
            op_d        = w_op;
            rd_d        = w_rd;
        end
        for (int i = 1; i < 32; i++) begin
            if (bus.wb_valid && bus.wb_rd == 5'(i)) busy_d[i] = 1'b0;
            if (w_fire && w_legal && w_rd == 5'(i)) busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            op_q        <= 4'd0;
            rd_q        <= 5'd0;
            illegal_q   <= 1'b0;
            busy_q      <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
            if (bus.wb_valid && bus.wb_rd != 5'd0) rf_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.ALU_Op    = op_q;
    assign bus.out_rd    = rd_q;
    assign bus.illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// ============================================================================
// Module      : tb_alu_issue
// Description : Directed vectors with a queue-based scoreboard for alu_issue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if bus();

    alu_issue #(.WB_BYPASS(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ill_pending = 0;

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] op, input logic [4:0] rd);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.rd = rd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every consumed output
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got rd %0d expected none", bus.out_rd);
            end else begin
                e = sb.pop_front();
                chk("mon_A", bus.A, e.a);
                chk("mon_B", bus.B, e.b);
                chk("mon_ALU_Op", 32'(bus.ALU_Op), 32'(e.op));
                chk("mon_out_rd", 32'(bus.out_rd), 32'(e.rd));
            end
        end
        if (rst_n && bus.illegal) begin
            checks++;
            if (ill_pending == 0) begin
                errors++;
                $display("FAIL unexpected_illegal: got 1 expected 0");
            end else begin
                ill_pending--;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = r;
        bus.wb_data  = d;
        cyc();
        bus.wb_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr, input exp_t e, input bit legal);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: instr %h got in_ready 0 expected 1", instr);
            cyc();
            bus.in_valid = 1'b0;
            return;
        end
        if (legal) sb.push_back(e);
        else ill_pending++;
        cyc();
        bus.in_valid = 1'b0;
        bus.in_instr = 32'd0;
        @(negedge clk);
        if (legal) begin
            chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
        end else begin
            chk("illegal_pulse", 32'(bus.illegal), 32'd1);
            chk("illegal_no_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            chk("illegal_one_cycle", 32'(bus.illegal), 32'd0);
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_illegal",   32'(bus.illegal),   32'd0);
        chk("rst_A",         bus.A,              32'd0);
        chk("rst_B",         bus.B,              32'd0);
        chk("rst_ALU_Op",    32'(bus.ALU_Op),    32'd0);
        chk("rst_out_rd",    32'(bus.out_rd),    32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        cyc();

        wb(5'd1, 32'd3);
        wb(5'd2, 32'd2);
        issue(32'h002081B3, mk(32'd3, 32'd2, 4'b0000, 5'd3), 1'b1);

        // RAW on x3 resolved by a forwarded writeback
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00118233;
        repeat (3) begin
            @(negedge clk);
            chk("raw_stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        cyc();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd3;
        bus.wb_data  = 32'd5;
        @(negedge clk);
        chk("raw_bypass_in_ready", 32'(bus.in_ready), 32'd1);
        sb.push_back(mk(32'd5, 32'd3, 4'b0000, 5'd4));
        cyc();
        bus.in_valid = 1'b0;
        bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("raw_out_valid", 32'(bus.out_valid), 32'd1);
        cyc();
        wb(5'd4, 32'd8);

        issue(32'h402081B3, mk(32'd3, 32'd2, 4'b1000, 5'd3), 1'b1);
        wb(5'd3, 32'd1);
        issue(32'h4040D293, mk(32'd3, 32'd4, 4'b1101, 5'd5), 1'b1);
        wb(5'd5, 32'd0);
        issue(32'hFFF00093, mk(32'd0, 32'hFFFFFFFF, 4'b0000, 5'd1), 1'b1);
        wb(5'd1, 32'd3);

        // Backpressure: and x6 held while or x7 waits
        bus.out_ready = 1'b0;
        issue(32'h0020F333, mk(32'd3, 32'd2, 4'b0111, 5'd6), 1'b1);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h0020E3B3;
        repeat (3) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_A",         bus.A,              32'd3);
            chk("hold_B",         bus.B,              32'd2);
            chk("hold_ALU_Op",    32'(bus.ALU_Op),    32'd7);
            chk("hold_out_rd",    32'(bus.out_rd),    32'd6);
            chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
        end
        cyc();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        sb.push_back(mk(32'd3, 32'd2, 4'b0110, 5'd7));
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_out_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_out_rd",    32'(bus.out_rd),    32'd7);
        cyc();
        wb(5'd6, 32'd0);
        wb(5'd7, 32'd0);

        issue(32'h00002083, mk(32'd0, 32'd0, 4'd0, 5'd0), 1'b0);
        issue(32'h402091B3, mk(32'd0, 32'd0, 4'd0, 5'd0), 1'b0);
        issue(32'h40209193, mk(32'd0, 32'd0, 4'd0, 5'd0), 1'b0);
        wb(5'd0, 32'd7);
        issue(32'h00500413, mk(32'd0, 32'd5, 4'b0000, 5'd8), 1'b1);
        wb(5'd8, 32'd0);
        issue(32'h01F09493, mk(32'd3, 32'd31, 4'b0001, 5'd9), 1'b1);
        wb(5'd9, 32'd0);
        issue(32'h0020B533, mk(32'd3, 32'd2, 4'b0011, 5'd10), 1'b1);

        // Reset with a pending output and busy x3
        bus.out_ready = 1'b0;
        issue(32'h002081B3, mk(32'd3, 32'd2, 4'b0000, 5'd3), 1'b1);
        rst_n = 1'b0;
        sb.delete();
        cyc();
        @(negedge clk);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready",  32'(bus.in_ready),  32'd0);
        cyc();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00118233;
        @(negedge clk);
        chk("after_rst_in_ready", 32'(bus.in_ready), 32'd1);
        sb.push_back(mk(32'd0, 32'd0, 4'b0000, 5'd4));
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("after_rst_out_valid", 32'(bus.out_valid), 32'd1);
        cyc();
        cyc();

        chk("sb_empty",      32'(sb.size()),   32'd0);
        chk("illegal_drain", 32'(ill_pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter WB_BYPASS, default 1: when 1, a same-cycle writeback is forwarded to the operand read and clears the hazard for that register.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 in_valid  in  1  in_instr holds an instruction.
REQ-006 in_ready  out  1  block accepts in_instr this cycle.
REQ-007 in_instr  in  32  RV32I instruction word.
REQ-008 out_valid  out  1  A/B/ALU_Op/out_rd valid for the ALU.
REQ-009 out_ready  in  1  ALU consumes the output this cycle.
REQ-010 A  out  32  operand A, the rs1 value.
REQ-011 B  out  32  operand B, the rs2 value or immediate.
REQ-012 ALU_Op  out  4  ALU operation code.
REQ-013 out_rd  out  5  destination register tag.
REQ-014 wb_valid  in  1  writeback strobe.
REQ-015 wb_rd  in  5  writeback register.
REQ-016 wb_data  in  32  writeback value (ALU_Result).
REQ-017 illegal  out  1  one-cycle pulse when an unsupported instruction is consumed.

Function
REQ-018 SHALL hold a 32x32 register file; x0 reads 0, writes to x0 ignored.
REQ-019 SHALL accept only opcode 0110011 (OP) and 0010011 (OP-IMM); any other opcode is consumed as illegal.
REQ-020 OP: ALU_Op = {instr[30], funct3}; funct7 SHALL be 0000000, or 0100000 only with funct3 000/101; otherwise illegal.
REQ-021 OP-IMM: ALU_Op = {0, funct3}, B = sign-extended instr[31:20]; funct3 001 requires instr[31:25]=0; funct3 101 requires instr[31:25] = 0000000 (ALU_Op 0101) or 0100000 (ALU_Op 1101); B = zero-extended shamt instr[24:20] for shifts; other funct7 values are illegal.
REQ-022 Encodings: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-023 Scoreboard busy[31:1]: set on accept of a legal instruction with rd!=0; cleared on wb_valid for wb_rd!=0; simultaneous set and clear of the same register leaves it set.
REQ-024 Hazard = busy[rs1], OR busy[rs2] (OP only), OR busy[rd]; with WB_BYPASS=1 a register matching wb_rd under wb_valid does not count as busy.
REQ-025 in_ready = (!out_valid || out_ready) && !hazard; transfer occurs when in_valid && in_ready.
REQ-026 Illegal instructions ignore the hazard term, always transfer when !out_valid || out_ready, pulse illegal the next cycle, and do not assert out_valid or touch the scoreboard.
REQ-027 Latency: out_valid rises the cycle after a legal transfer; A/B/ALU_Op/out_rd are registered.
REQ-028 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-029 out_valid drops after out_ready unless a new transfer occurs in the same cycle (back-to-back, 1 instr/cycle).
REQ-030 Writeback updates the register file at the clock edge; a same-cycle read of wb_rd returns wb_data when WB_BYPASS=1.

Reset
REQ-031 While rst_n=0 at a clock edge: out_valid=0, illegal=0, A=B=0, ALU_Op=0, out_rd=0, busy=0, all registers=0, in_ready=0.
REQ-032 Reset mid-operation SHALL discard any pending output and pending hazards; the first cycle after release presents in_ready=1.

Verification
REQ-033 Write x1=3, x2=2 via wb; issue 0x002081B3 (add x3,x1,x2) -> next cycle out_valid=1, A=3, B=2, ALU_Op=0000, out_rd=3.
REQ-034 Issue 0x402081B3 (sub) -> ALU_Op=1000; 0x4040D293 (srai x5,x1,4) -> A=3, B=4, ALU_Op=1101; 0xFFF00093 (addi x1,x0,-1) -> A=0, B=0xFFFFFFFF.
REQ-035 RAW: add x3 then add x4,x3,x1 -> in_ready=0 until wb_valid, wb_rd=3, wb_data=5; accepted that cycle with A=5.
REQ-036 Hold out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; release -> next instr in one cycle.
REQ-037 Issue 0x00002083 (load) -> illegal=1 for one cycle, out_valid stays 0; wb x0=7 then read x0 -> A=0.
REQ-038 Assert rst_n=0 with out_valid=1 and busy[3]=1 -> next cycle out_valid=0 and busy cleared; after release an instruction reading x3 is accepted immediately.
